cache_ctrl: RTL

- Direct-mapped, write-back, write-allocate cache controller for one 32-bit core port.
- Initiator for one status/tag RAM and one line-data RAM; both RAMs are synchronous and return read data one clock after the address is presented.
- Runs hit/miss lookup, dirty-line writeback and line fill against a line-wide memory port.
- Sits between the core load/store unit and the memory/bus interface.

---
 rtl/cache_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller for a single 32-bit core port.
// Drives an external status/tag RAM, a line-data RAM (both 1-cycle synchronous read) and a line-wide memory port.
module cache_ctrl #(
    parameter  int tag_len    = 13,
    parameter  int index_len  = 10,
    parameter  int offset_len = 4,
    localparam int AW         = tag_len + index_len + offset_len,
    localparam int LW         = 32 * (2 ** (offset_len - 2))
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [AW-1:0]        req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic [index_len-1:0] ram_addr,
    output logic                 st_we,
    output logic                 st_re,
    output logic [tag_len-1:0]   tag_wr,
    output logic [2:0]           status_wr,
    input  logic [tag_len-1:0]   tag_rd,
    input  logic [2:0]           status_rd,
    output logic                 data_we,
    output logic [LW-1:0]        data_wr,
    input  logic [LW-1:0]        data_rd,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [LW-1:0]        mem_wdata,
    input  logic                 mem_ack,
    input  logic [LW-1:0]        mem_rdata
);

    localparam int WL = offset_len - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_UPDATE,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [AW-1:0]        r_addr;
    logic                 r_we;
    logic [31:0]          r_wdata;
    logic [tag_len-1:0]   r_vic_tag;
    logic [LW-1:0]        r_vic_line;
    logic [LW-1:0]        r_fill;
    logic [31:0]          r_rdata;

    logic [tag_len-1:0]   w_tag;
    logic [index_len-1:0] w_idx;
    logic [WL-1:0]        w_word;
    logic                 w_hit;
    logic                 w_dirty;
    logic                 w_unused;

    assign w_tag    = r_addr[AW-1:index_len+offset_len];
    assign w_idx    = r_addr[index_len+offset_len-1:offset_len];
    assign w_word   = r_addr[offset_len-1:2];
    assign w_hit    = status_rd[0] & (tag_rd == w_tag);
    assign w_dirty  = (status_rd[1:0] == 2'b11);
    assign w_unused = ^{status_rd[2], r_addr[1:0]};

    assign resp_rdata = r_rdata;

    function automatic logic [LW-1:0] merge_word(input logic [LW-1:0] line,
                                                 input logic [WL-1:0] word,
                                                 input logic [31:0]   wd);
        logic [LW-1:0] l;
        l = line;
        l[word*32 +: 32] = wd;
        return l;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_vic_tag  <= '0;
            r_vic_line <= '0;
            r_fill     <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit && !r_we) begin
                        r_rdata <= data_rd[w_word*32 +: 32];
                    end else if (!w_hit && w_dirty) begin
                        // RAM outputs are only valid this cycle, so the victim is copied out now
                        r_vic_tag  <= tag_rd;
                        r_vic_line <= data_rd;
                    end
                end
                S_FILL: begin
                    if (mem_ack) r_fill <= mem_rdata;
                end
                S_UPDATE: begin
                    if (!r_we) r_rdata <= r_fill[w_word*32 +: 32];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_addr   = w_idx;
        st_we      = 1'b0;
        st_re      = 1'b0;
        tag_wr     = w_tag;
        status_wr  = 3'b000;
        data_we    = 1'b0;
        data_wr    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                // rstn gates the handshake so nothing is accepted or read while reset is held
                req_ready = rstn;
                st_re     = req_valid & rstn;
                ram_addr  = req_addr[index_len+offset_len-1:offset_len];
                if (req_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    if (r_we) begin
                        st_we     = 1'b1;
                        status_wr = 3'b011;
                        data_we   = 1'b1;
                        data_wr   = merge_word(data_rd, w_word, r_wdata);
                    end
                    w_next = S_RESP;
                end else if (w_dirty) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_vic_tag, w_idx, {offset_len{1'b0}}};
                mem_wdata = r_vic_line;
                if (mem_ack) w_next = S_FILL;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, {offset_len{1'b0}}};
                if (mem_ack) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                st_we     = 1'b1;
                data_we   = 1'b1;
                status_wr = r_we ? 3'b011 : 3'b001;
                data_wr   = r_we ? merge_word(r_fill, w_word, r_wdata) : r_fill;
                w_next    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
